// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
//   Samples N_CH level inputs and detects rising/falling edges per channel.
//   Each channel holds at most one pending event. Pending events are granted
//   round-robin onto a single valid/ready event port. An event lost because
//   its channel slot was still occupied sets a sticky per-channel overflow bit.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   a          level inputs, synchronous to clk
//   en         per-channel edge-detect enable (does not affect pending events)
//   evt_ready  consumer accepts the currently presented event
//   evt_valid  event present on evt_ch / evt_rise
//   evt_ch     channel id of the presented event
//   evt_rise   1 = rising edge, 0 = falling edge
//   ovf        sticky per-channel overflow flags
//   ovf_clr    clear all overflow flags (a same-cycle new overflow still sets)

module edge_event_arbiter #(
    parameter int N_CH = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] a,
    input  logic [N_CH-1:0] en,
    input  logic            evt_ready,
    output logic            evt_valid,
    output logic [ID_W-1:0] evt_ch,
    output logic            evt_rise,
    output logic [N_CH-1:0] ovf,
    input  logic            ovf_clr
);

    localparam logic [ID_W:0]   N_CH_W  = (ID_W+1)'(N_CH);
    localparam logic [ID_W-1:0] LAST_CH = ID_W'(N_CH - 1);

    logic [N_CH-1:0] a_d_q,  a_d_d;
    logic [N_CH-1:0] pend_q, pend_d;
    logic [N_CH-1:0] ptyp_q, ptyp_d;
    logic [N_CH-1:0] ovf_q,  ovf_d;
    logic [ID_W-1:0] ptr_q,  ptr_d;
    logic            evt_valid_q, evt_valid_d;
    logic [ID_W-1:0] evt_ch_q,    evt_ch_d;
    logic            evt_rise_q,  evt_rise_d;

    logic [N_CH-1:0] rdet;
    logic [N_CH-1:0] fdet;
    logic [N_CH-1:0] det;
    logic            load;
    logic            found;
    logic [ID_W-1:0] gnt_idx;
    logic            gnt_fire;
    logic [N_CH-1:0] gnt_vec;
    logic [N_CH-1:0] slot_free;
    logic [N_CH-1:0] accept;
    logic [N_CH-1:0] ovf_set;

    // Edge detection against the previous sample; the sample register runs
    // regardless of en so re-enabling a channel never fabricates an edge.
    always_comb begin
        a_d_d = a;
        rdet  = en & a & ~a_d_q;
        fdet  = en & ~a & a_d_q;
        det   = rdet | fdet;
    end

    // The output register may take a new event when empty or being consumed.
    always_comb begin
        load = ~evt_valid_q | evt_ready;
    end

    // Round-robin search: first pending channel at ptr, ptr+1, ... mod N_CH.
    always_comb begin
        logic [ID_W:0] cand;
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < N_CH; k++) begin
            cand = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (cand >= N_CH_W) begin
                cand = cand - N_CH_W;
            end
            if (!found && pend_q[cand[ID_W-1:0]]) begin
                found   = 1'b1;
                gnt_idx = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_fire = load & found;
        gnt_vec  = '0;
        if (gnt_fire) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

    // A slot being granted this cycle counts as free, so a detect on the
    // granted channel replaces the outgoing entry without overflowing.
    always_comb begin
        slot_free = ~pend_q | gnt_vec;
        accept    = det & slot_free;
        ovf_set   = det & ~slot_free;
        pend_d    = (pend_q & ~gnt_vec) | accept;
        ptyp_d    = (accept & rdet) | (~accept & ptyp_q);
        ovf_d     = (ovf_clr ? '0 : ovf_q) | ovf_set;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_fire) begin
            ptr_d = (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Channel/type only change on a grant; they hold while stalled and
    // keep their last value when the port goes idle.
    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        evt_rise_d  = evt_rise_q;
        if (load) begin
            evt_valid_d = found;
            if (found) begin
                evt_ch_d   = gnt_idx;
                evt_rise_d = ptyp_q[gnt_idx];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_d_q       <= '0;
            pend_q      <= '0;
            ptyp_q      <= '0;
            ovf_q       <= '0;
            ptr_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            evt_rise_q  <= 1'b0;
        end else begin
            a_d_q       <= a_d_d;
            pend_q      <= pend_d;
            ptyp_q      <= ptyp_d;
            ovf_q       <= ovf_d;
            ptr_q       <= ptr_d;
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
            evt_rise_q  <= evt_rise_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_ch    = evt_ch_q;
    assign evt_rise  = evt_rise_q;
    assign ovf       = ovf_q;

endmodule
